// File: rtl/arcade_input_ctrl.sv
// Player-input conditioning: PS/2 + joystick decode, P2->P1 merge, frame-timed coin pulses; optional INP_AUTOFIRE_EN.
// Latency 1 clk from joystick, 2 clk from ps2 toggle; coin pulse lasts COIN_FRAMES ticks. No backpressure.
module arcade_input_ctrl #(
  parameter int COIN_FRAMES = 3,
  parameter int GAP_FRAMES  = 2,
  parameter int AF_FRAMES   = 4
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        cabinet,
  input  logic        vblank,
  input  logic        autofire,
  output logic [5:0]  INP0,
  output logic [5:0]  INP1,
  output logic [2:0]  INP2
);

  localparam int MAX_CG  = (COIN_FRAMES > GAP_FRAMES) ? COIN_FRAMES : GAP_FRAMES;
  localparam int MAX_ALL = (MAX_CG > AF_FRAMES) ? MAX_CG : AF_FRAMES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_st_t;

  // Key latches use the output layout {trig2, trig1, left, down, right, up}
  logic [5:0] key_p1, key_p2;
  logic       key_f1, key_f2, key_start1, key_start2, key_coin1, key_coin2;
  logic       prev_tog, armed;
  logic       key_evt, pressed;
  logic [8:0] code;

  assign key_evt = armed && (ps2_key[10] != prev_tog);
  assign pressed = ps2_key[9];
  assign code    = ps2_key[8:0];

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_tog   <= 1'b0;
      armed      <= 1'b0;
      key_p1     <= '0;
      key_p2     <= '0;
      key_f1     <= 1'b0;
      key_f2     <= 1'b0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin1  <= 1'b0;
      key_coin2  <= 1'b0;
    end else begin
      prev_tog <= ps2_key[10];
      armed    <= 1'b1;
      if (key_evt) begin
        casez (code)
          9'b?0111_0101: key_p1[0]  <= pressed;
          9'b?0111_0100: key_p1[1]  <= pressed;
          9'b?0111_0010: key_p1[2]  <= pressed;
          9'b?0110_1011: key_p1[3]  <= pressed;
          9'h029:        key_p1[4]  <= pressed;
          9'h014:        key_p1[5]  <= pressed;
          9'h005:        key_f1     <= pressed;
          9'h006:        key_f2     <= pressed;
          9'h016:        key_start1 <= pressed;
          9'h01E:        key_start2 <= pressed;
          9'h02E:        key_coin1  <= pressed;
          9'h036:        key_coin2  <= pressed;
          9'h02D:        key_p2[0]  <= pressed;
          9'h034:        key_p2[1]  <= pressed;
          9'h02B:        key_p2[2]  <= pressed;
          9'h023:        key_p2[3]  <= pressed;
          9'h01C:        key_p2[4]  <= pressed;
          9'h01B:        key_p2[5]  <= pressed;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [5:0] joy_bits(input logic [15:0] j);
    return {j[5], j[4], j[1], j[2], j[0], j[3]};
  endfunction

  logic [5:0] p1_c, p2_c, p1_out, p2_out;
  logic       start1_c, start2_c, coin_req_c;

  always_comb begin
    p2_c       = key_p2 | joy_bits(joystk2);
    p1_c       = key_p1 | joy_bits(joystk1) | (cabinet ? 6'd0 : p2_c);
    start1_c   = key_f1 | key_start1 | joystk1[6] | joystk2[6];
    start2_c   = key_f2 | key_start2 | joystk1[7] | joystk2[7];
    coin_req_c = key_f1 | key_f2 | key_coin1 | key_coin2 | joystk1[8] | joystk2[8];
  end

  logic frame_tick, vblank_q;
  assign frame_tick = vblank & ~vblank_q;

`ifdef INP_AUTOFIRE_EN
  logic [CW-1:0] af_cnt;
  logic          af_phase;
  logic          unused_bits;
  assign unused_bits = ^{joystk1[15:9], joystk2[15:9]};

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (frame_tick) begin
      if (af_cnt == CW'(AF_FRAMES - 1)) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    p1_out    = p1_c;
    p2_out    = p2_c;
    p1_out[4] = p1_c[4] & (autofire ? af_phase : 1'b1);
    p2_out[4] = p2_c[4] & (autofire ? af_phase : 1'b1);
  end
`else
  logic unused_bits;
  assign unused_bits = ^{joystk1[15:9], joystk2[15:9], autofire};

  always_comb begin
    p1_out = p1_c;
    p2_out = p2_c;
  end
`endif

  logic [1:0] start_q;
  logic       coin_req_q, coin_req_d, coin_out;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      INP0       <= '0;
      INP1       <= '0;
      start_q    <= '0;
      coin_req_q <= 1'b0;
      coin_req_d <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      INP0       <= p1_out;
      INP1       <= p2_out;
      start_q    <= {start2_c, start1_c};
      coin_req_q <= coin_req_c;
      coin_req_d <= coin_req_q;
      vblank_q   <= vblank;
    end
  end

  assign INP2 = {coin_out, start_q};

  // Coin edges arriving outside IDLE are dropped, so a held or bouncing coin counts once
  coin_st_t      coin_st;
  logic [CW-1:0] cnt;
  logic          coin_edge;
  assign coin_edge = coin_req_q & ~coin_req_d;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      coin_st  <= IDLE;
      cnt      <= '0;
      coin_out <= 1'b0;
    end else begin
      case (coin_st)
        IDLE: begin
          if (coin_edge) begin
            coin_st  <= PULSE;
            cnt      <= CW'(COIN_FRAMES);
            coin_out <= 1'b1;
          end
        end
        PULSE: begin
          if (frame_tick) begin
            if (cnt <= CW'(1)) begin
              coin_out <= 1'b0;
              if (GAP_FRAMES == 0) begin
                coin_st <= WAIT_REL;
                cnt     <= '0;
              end else begin
                coin_st <= GAP;
                cnt     <= CW'(GAP_FRAMES);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        GAP: begin
          if (frame_tick) begin
            if (cnt <= CW'(1)) begin
              coin_st <= WAIT_REL;
              cnt     <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        WAIT_REL: begin
          if (!coin_req_q) coin_st <= IDLE;
        end
        default: coin_st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Input conditioning stage directly upstream of the game core player-input ports (INP0/INP1/INP2).
- Decodes PS/2 key events and the two MiSTer joystick words into latched per-button states.
- Merges player 2 controls into player 1 for the upright cabinet.
- Shapes coin requests into frame-timed pulses so the game CPU, which polls once per frame, never misses or double-counts a coin.

Parameters:
- COIN_FRAMES, 3, number of vblank rising edges the coin output stays high per accepted coin.
- GAP_FRAMES, 2, minimum vblank rising edges the coin output stays low after a pulse before another coin is accepted.
- AF_FRAMES, 4, autofire half-period in frames (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock (48 MHz).
- RESET_N  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle on each event, [9] pressed, [8:0] scan code with extended bit.
- joystk1  in  16  player 1 joystick: [0]R [1]L [2]D [3]U [4]Trig1 [5]Trig2 [6]Start1 [7]Start2 [8]Coin.
- joystk2  in  16  player 2 joystick, same bit layout.
- cabinet  in  1  1 = cocktail; 0 = upright, player 2 ORed into player 1.
- vblank  in  1  frame blank from the video timing generator, synchronous to clk_sys.
- autofire  in  1  autofire enable; ignored when the feature is compiled out.
- INP0  out  6  {trig2, trig1, left, down, right, up} for player 1.
- INP1  out  6  same layout for player 2.
- INP2  out  3  {coin, start2, start1}.

Behaviour:
- Clock and reset: one clock, clk_sys. RESET_N is asynchronous, active-low.
- Reset: all key latches, outputs, FSM state and counters clear to 0. Coin FSM enters IDLE.
- Key event detection:
  - Register prev_tog. A key event is ps2_key[10] != prev_tog.
  - An internal armed flag clears on reset. The first clock after reset copies ps2_key[10] into prev_tog, sets armed, and decodes nothing. This prevents a spurious event when the toggle bit is already 1.
- Key map: each latch takes the pressed bit on an event with a matching code.
  - Extended don't-care codes: x75 up, x72 down, x6B left, x74 right.
  - Exact codes: 029 trig1, 014 trig2, 005 F1, 006 F2, 016 start1, 01E start2, 02E coin1, 036 coin2.
  - Player 2 exact codes: 02D up2, 02B down2, 023 left2, 034 right2, 01C trig1_2, 01B trig2_2.
  - Other codes leave all latches unchanged.
- Combine (combinational, then registered):
  - p2 bit = key2 | joystk2 bit.
  - p1 bit = key1 | joystk1 bit | (cabinet ? 0 : p2 bit).
  - start1 = F1 | start1 key | joystk1[6] | joystk2[6].
  - start2 = F2 | start2 key | joystk1[7] | joystk2[7].
  - coin_req = F1 | F2 | coin1 | coin2 | joystk1[8] | joystk2[8].
- Latency: INP0, INP1, INP2[1:0] are registered, 1 clk after the joystick input changes, or 2 clk after a ps2 toggle.
- Frame tick: vblank rising edge, detected with a 1-clk delayed register.
- Coin FSM (drives INP2[2] high only in PULSE):
  - IDLE: a coin_req rising edge loads cnt=COIN_FRAMES and goes to PULSE; INP2[2] goes high on the next clk.
  - PULSE: cnt decrements on each frame tick. At 0, load cnt=GAP_FRAMES and go to GAP.
  - GAP: cnt decrements on frame ticks. At 0, go to WAIT_REL.
  - WAIT_REL: return to IDLE once coin_req==0. Holding coin therefore yields exactly one pulse.
  - A coin_req edge during PULSE or GAP is dropped, not queued.
  - A frame tick and a coin_req edge in the same clk while in IDLE: enter PULSE; that tick does not decrement.
  - Counter width is clog2(max(COIN_FRAMES, GAP_FRAMES, AF_FRAMES)+1). COIN_FRAMES=0 is illegal.
- Reset asserted mid-pulse: INP2[2] drops asynchronously, FSM goes to IDLE, and armed clears.

Optional Feature:
- Macro: INP_AUTOFIRE_EN.
- Defined:
  - A frame-tick counter toggles af_phase every AF_FRAMES ticks.
  - While autofire=1 and the player's trig1 source is held, INP0[4] and INP1[4] output trig1 & af_phase.
  - af_phase resets to 1, so the first frame fires.
  - autofire=0 passes trig1 through unchanged.
- Undefined: no autofire logic. The autofire port is present but ignored, and trig1 always passes through.

Test Plan:
- Reset release with ps2_key[10]=1 and no toggle -> INP0/INP1/INP2 stay 0 for 100 clks with no spurious latch.
- ps2_key toggles with {pressed=1, code=0x175}, then toggles with pressed=0 -> INP0[0] goes 1 two clks after the first toggle and 0 two clks after the second.
- cabinet=0, joystk2[4]=1 -> INP0[4]=1 and INP1[4]=1 after 1 clk. With cabinet=1 -> INP0[4]=0.
- joystk1[8] held for 20 frames, COIN_FRAMES=3, GAP_FRAMES=2 -> exactly one INP2[2] pulse spanning 3 vblank edges. After release and reassertion, a second pulse occurs.
- Second coin edge at frame 1 of PULSE -> ignored. Total pulse count stays 1. RESET_N low mid-pulse -> INP2[2]=0 immediately.
- With INP_AUTOFIRE_EN defined, autofire=1, trig1 held, AF_FRAMES=4 -> INP0[4] alternates 4 frames high, 4 frames low, starting high.
